// File: rtl/riscv_defs.sv
// Shared definitions for the instruction cache: geometry, FSM states and address layout.
package riscv_defs;

    localparam int unsigned ICACHE_INDEX_BITS  = 4;
    localparam int unsigned ICACHE_OFFSET_BITS = 2;
    localparam int unsigned ICACHE_TAG_BITS    = 32 - 2 - ICACHE_OFFSET_BITS - ICACHE_INDEX_BITS;
    localparam int unsigned ICACHE_LINES       = 1 << ICACHE_INDEX_BITS;
    localparam int unsigned ICACHE_LINE_WORDS  = 1 << ICACHE_OFFSET_BITS;

    typedef enum logic {
        IC_IDLE = 1'b0,
        IC_FILL = 1'b1
    } ic_state_e;

    // One cache line, word 0 at the lowest address
    typedef logic [ICACHE_LINE_WORDS-1:0][31:0] ic_line_t;

    // Fetch address viewed as tag / index / word-in-line / byte-in-word
    typedef struct packed {
        logic [ICACHE_TAG_BITS-1:0]    tag;
        logic [ICACHE_INDEX_BITS-1:0]  index;
        logic [ICACHE_OFFSET_BITS-1:0] word;
        logic [1:0]                    byte_off;
    } ic_addr_t;

    function automatic ic_addr_t ic_split(input logic [31:0] pc);
        return ic_addr_t'(pc);
    endfunction

endpackage

// File: rtl/icache_array.sv
// Tag, valid and data storage: combinational read by index, synchronous whole-line write.
module icache_array
    import riscv_defs::*;
(
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [ICACHE_INDEX_BITS-1:0] rd_index_i,
    output logic                         rd_valid_o,
    output logic [ICACHE_TAG_BITS-1:0]   rd_tag_o,
    output ic_line_t                     rd_line_o,
    input  logic                         wr_en_i,
    input  logic [ICACHE_INDEX_BITS-1:0] wr_index_i,
    input  logic [ICACHE_TAG_BITS-1:0]   wr_tag_i,
    input  ic_line_t                     wr_line_i
);

    logic [ICACHE_LINES-1:0]    valid_q;
    logic [ICACHE_TAG_BITS-1:0] tag_q  [ICACHE_LINES];
    ic_line_t                   data_q [ICACHE_LINES];

    // Valid bits: cleared by reset, set when a line is installed
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    // Tag and data storage; contents are meaningless until the valid bit is set
    always_ff @(posedge clk_in) begin
        if (wr_en_i) begin
            tag_q[wr_index_i]  <= wr_tag_i;
            data_q[wr_index_i] <= wr_line_i;
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_line_o  = data_q[rd_index_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: 1-cycle hits, blocking line fills from the memory controller.
module icache
    import riscv_defs::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        fetch_req,
    input  logic [31:0] fetch_pc,
    input  logic        fetch_clear,
    output logic        fetch_ready,
    output logic [31:0] fetch_inst,
    output logic        mc_query_en,
    output logic [31:0] mc_query_addr,
    input  logic        mc_result_en,
    input  logic [31:0] mc_result_data
);

    localparam int unsigned CNT_BITS  = ICACHE_OFFSET_BITS + 1;
    localparam int unsigned LINE_LSBS = 2 + ICACHE_OFFSET_BITS;
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(ICACHE_LINE_WORDS - 1);

    ic_state_e                     state_q;
    logic [CNT_BITS-1:0]           cnt_q;
    logic [ICACHE_OFFSET_BITS-1:0] word_q;
    logic                          cancel_q;
    ic_line_t                      fill_buf_q;

    ic_addr_t                      req_a;
    logic                          rd_valid;
    logic [ICACHE_TAG_BITS-1:0]    rd_tag;
    ic_line_t                      rd_line;
    logic                          hit_c;
    logic                          install_c;
    ic_line_t                      fill_line_c;
    logic                          unused_byte_off;

    assign req_a           = ic_split(fetch_pc);
    assign hit_c           = rd_valid && (rd_tag == req_a.tag);
    assign unused_byte_off = ^req_a.byte_off;

    // Line being installed: buffered words plus the word arriving this cycle
    always_comb begin
        fill_line_c = fill_buf_q;
        fill_line_c[cnt_q[ICACHE_OFFSET_BITS-1:0]] = mc_result_data;
    end

    assign install_c = !rst_in && rdy_in && (state_q == IC_FILL)
                       && mc_result_en && (cnt_q == CNT_LAST);

    icache_array u_array (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rd_index_i (req_a.index),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_line_o  (rd_line),
        .wr_en_i    (install_c),
        .wr_index_i (mc_query_addr[LINE_LSBS +: ICACHE_INDEX_BITS]),
        .wr_tag_i   (mc_query_addr[31 -: ICACHE_TAG_BITS]),
        .wr_line_i  (fill_line_c)
    );

    // Lookup / fill FSM with registered fetch and memory-request outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= IC_IDLE;
            cnt_q         <= '0;
            word_q        <= '0;
            cancel_q      <= 1'b0;
            fill_buf_q    <= '0;
            fetch_ready   <= 1'b0;
            fetch_inst    <= '0;
            mc_query_en   <= 1'b0;
            mc_query_addr <= '0;
        end else if (rdy_in) begin
            fetch_ready <= 1'b0;
            case (state_q)
                IC_IDLE: begin
                    cancel_q <= 1'b0;
                    // The cycle carrying a ready pulse never accepts a new request
                    if (fetch_req && !fetch_clear && !fetch_ready) begin
                        if (hit_c) begin
                            fetch_ready <= 1'b1;
                            fetch_inst  <= rd_line[req_a.word];
                        end else begin
                            mc_query_en   <= 1'b1;
                            mc_query_addr <= {fetch_pc[31:LINE_LSBS], LINE_LSBS'(0)};
                            word_q        <= req_a.word;
                            cnt_q         <= '0;
                            state_q       <= IC_FILL;
                        end
                    end
                end
                IC_FILL: begin
                    if (fetch_clear) begin
                        cancel_q <= 1'b1;
                    end
                    if (mc_result_en) begin
                        fill_buf_q[cnt_q[ICACHE_OFFSET_BITS-1:0]] <= mc_result_data;
                        cnt_q <= cnt_q + CNT_BITS'(1);
                        if (cnt_q == CNT_LAST) begin
                            mc_query_en <= 1'b0;
                            state_q     <= IC_IDLE;
                            // Forward the requested word from the assembled line
                            if (!cancel_q && !fetch_clear) begin
                                fetch_ready <= 1'b1;
                                fetch_inst  <= fill_line_c[word_q];
                            end
                        end
                    end
                end
                default: state_q <= IC_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus randomized fetch streams.
module tb_icache;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        fetch_clear;
    logic        fetch_ready;
    logic [31:0] fetch_inst;
    logic        mc_query_en;
    logic [31:0] mc_query_addr;
    logic        mc_result_en;
    logic [31:0] mc_result_data;

    icache dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .fetch_req      (fetch_req),
        .fetch_pc       (fetch_pc),
        .fetch_clear    (fetch_clear),
        .fetch_ready    (fetch_ready),
        .fetch_inst     (fetch_inst),
        .mc_query_en    (mc_query_en),
        .mc_query_addr  (mc_query_addr),
        .mc_result_en   (mc_result_en),
        .mc_result_data (mc_result_data)
    );

    always #5 clk_in = ~clk_in;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] seed;

    // Reference model: which line (tag) each of the 16 sets holds
    logic [15:0] m_valid;
    logic [23:0] m_tag [16];

    // Expected output values
    logic        e_ready;
    logic [31:0] e_inst;
    logic        e_qen;
    logic [31:0] e_qaddr;

    // Memory contents as seen through the memory controller
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    // One fetch of pc; fill-phase events are scheduled before fill word N:
    // clear_at 0..3 = clear pulse, 5 = clear with the last word; pause_at = 3 paused cycles; rst_at = reset
    task automatic do_fetch(input logic [31:0] pc, input int clear_at, input int pause_at,
                            input int rst_at, input string nm);
        int          idx;
        int          done;
        int          sched[$];
        logic        hit;
        logic        cancelled;
        logic        aborted;
        logic [31:0] line;
        idx  = int'(pc[7:4]);
        line = {pc[31:4], 4'h0};
        hit  = m_valid[idx] && (m_tag[idx] == pc[31:8]);
        fetch_req   = 1'b1;
        fetch_pc    = pc;
        fetch_clear = 1'b0;
        @(negedge clk_in);
        if (hit) begin
            e_ready = 1'b1;
            e_inst  = mem_word({pc[31:2], 2'b00});
        end else begin
            e_ready = 1'b0;
            e_qen   = 1'b1;
            e_qaddr = line;
        end
        n_vec++;
        if ({fetch_ready, fetch_inst, mc_query_en, mc_query_addr} !== {e_ready, e_inst, e_qen, e_qaddr}) begin
            n_bad++;
            $display("FAIL %s/first pc=%h: rdy/inst/qen/qaddr got %b/%h/%b/%h want %b/%h/%b/%h",
                     nm, pc, fetch_ready, fetch_inst, mc_query_en, mc_query_addr,
                     e_ready, e_inst, e_qen, e_qaddr);
        end
        if (!hit) begin
            for (int w = 0; w < 4; w++) begin
                if (w == rst_at) sched.push_back(5);
                if (w == clear_at) sched.push_back(2);
                if (w == pause_at) repeat (3) sched.push_back(3);
                repeat ($urandom_range(0, 2)) sched.push_back(0);
                sched.push_back((w == 3 && clear_at == 5) ? 4 : 1);
            end
            cancelled = 1'b0;
            aborted   = 1'b0;
            done      = 0;
            for (int k = 0; k < sched.size() && !aborted; k++) begin
                fetch_pc = $urandom;
                case (sched[k])
                    1: begin
                        mc_result_en   = 1'b1;
                        mc_result_data = mem_word(line + 32'(4 * done));
                    end
                    2: begin
                        fetch_clear = 1'b1;
                        cancelled   = 1'b1;
                    end
                    3: begin
                        rdy_in         = 1'b0;
                        mc_result_en   = 1'b1;
                        mc_result_data = $urandom;
                    end
                    4: begin
                        mc_result_en   = 1'b1;
                        mc_result_data = mem_word(line + 32'(4 * done));
                        fetch_clear    = 1'b1;
                        cancelled      = 1'b1;
                    end
                    5: rst_in = 1'b1;
                    default: ;
                endcase
                @(negedge clk_in);
                if (sched[k] == 5) begin
                    aborted = 1'b1;
                    e_ready = 1'b0;
                    e_inst  = '0;
                    e_qen   = 1'b0;
                    e_qaddr = '0;
                    m_valid = '0;
                end else if (sched[k] == 1 || sched[k] == 4) begin
                    done++;
                    if (done == 4) begin
                        e_qen   = 1'b0;
                        e_ready = !cancelled;
                        if (!cancelled) e_inst = mem_word({pc[31:2], 2'b00});
                        m_valid[idx] = 1'b1;
                        m_tag[idx]   = pc[31:8];
                    end
                end
                mc_result_en = 1'b0;
                fetch_clear  = 1'b0;
                rdy_in       = 1'b1;
                rst_in       = 1'b0;
                n_vec++;
                if ({fetch_ready, fetch_inst, mc_query_en, mc_query_addr} !== {e_ready, e_inst, e_qen, e_qaddr}) begin
                    n_bad++;
                    $display("FAIL %s/fill pc=%h step=%0d code=%0d: rdy/inst/qen/qaddr got %b/%h/%b/%h want %b/%h/%b/%h",
                             nm, pc, k, sched[k], fetch_ready, fetch_inst, mc_query_en, mc_query_addr,
                             e_ready, e_inst, e_qen, e_qaddr);
                end
            end
        end
        fetch_req = 1'b0;
        @(negedge clk_in);
        e_ready = 1'b0;
        n_vec++;
        if ({fetch_ready, fetch_inst, mc_query_en, mc_query_addr} !== {e_ready, e_inst, e_qen, e_qaddr}) begin
            n_bad++;
            $display("FAIL %s/release pc=%h: rdy/inst/qen/qaddr got %b/%h/%b/%h want %b/%h/%b/%h",
                     nm, pc, fetch_ready, fetch_inst, mc_query_en, mc_query_addr,
                     e_ready, e_inst, e_qen, e_qaddr);
        end
    endtask

    task automatic test_reset();
        fetch_req      = 1'b0;
        fetch_pc       = '0;
        fetch_clear    = 1'b0;
        mc_result_en   = 1'b0;
        mc_result_data = '0;
        rdy_in         = 1'b1;
        m_valid        = '0;
        e_ready        = 1'b0;
        e_inst         = '0;
        e_qen          = 1'b0;
        e_qaddr        = '0;
        for (int c = 0; c < 3; c++) begin
            rst_in = (c < 2);
            @(negedge clk_in);
            n_vec++;
            if ({fetch_ready, fetch_inst, mc_query_en, mc_query_addr} !== {e_ready, e_inst, e_qen, e_qaddr}) begin
                n_bad++;
                $display("FAIL reset cycle=%0d: rdy/inst/qen/qaddr got %b/%h/%b/%h want all zero",
                         c, fetch_ready, fetch_inst, mc_query_en, mc_query_addr);
            end
        end
    endtask

    task automatic test_cold_miss();
        do_fetch(32'h0000_1004, -1, -1, -1, "cold_miss");
    endtask

    task automatic test_hit();
        do_fetch(32'h0000_1008, -1, -1, -1, "hit_after_fill");
        do_fetch(32'h0000_100C, -1, -1, -1, "hit_word3");
    endtask

    task automatic test_conflict();
        do_fetch(32'h0000_1100, -1, -1, -1, "conflict_new_tag");
        do_fetch(32'h0000_1000, -1, -1, -1, "conflict_refetch");
    endtask

    task automatic test_clear_fill();
        do_fetch(32'h0000_1100, -1, -1, -1, "evict_for_clear");
        do_fetch(32'h0000_1000, 2, -1, -1, "clear_in_fill");
        do_fetch(32'h0000_1000, -1, -1, -1, "hit_after_clear");
        do_fetch(32'h0000_2044, 5, -1, -1, "clear_with_last");
        do_fetch(32'h0000_2048, -1, -1, -1, "hit_after_last_clear");
    endtask

    // Clear in IDLE suppresses hit and miss; stray result pulses while idle are ignored
    task automatic test_idle_clear();
        for (int c = 0; c < 4; c++) begin
            fetch_req      = 1'b1;
            fetch_clear    = 1'b1;
            fetch_pc       = (c % 2 == 0) ? 32'h0000_1000 : 32'h0000_5000;
            mc_result_en   = 1'b1;
            mc_result_data = $urandom;
            @(negedge clk_in);
            e_ready = 1'b0;
            n_vec++;
            if ({fetch_ready, fetch_inst, mc_query_en, mc_query_addr} !== {e_ready, e_inst, e_qen, e_qaddr}) begin
                n_bad++;
                $display("FAIL idle_clear cycle=%0d: rdy/inst/qen/qaddr got %b/%h/%b/%h want %b/%h/%b/%h",
                         c, fetch_ready, fetch_inst, mc_query_en, mc_query_addr,
                         e_ready, e_inst, e_qen, e_qaddr);
            end
        end
        fetch_req    = 1'b0;
        fetch_clear  = 1'b0;
        mc_result_en = 1'b0;
        @(negedge clk_in);
        do_fetch(32'h0000_1004, -1, -1, -1, "hit_after_idle_pulses");
    endtask

    // Pause holds a ready pulse; pause mid-fill ignores result pulses
    task automatic test_pause();
        for (int c = 0; c < 5; c++) begin
            if (c == 0) begin
                fetch_req = 1'b1;
                fetch_pc  = 32'h0000_1008;
            end
            if (c == 1) begin
                rdy_in    = 1'b0;
                fetch_req = 1'b0;
            end
            if (c == 4) rdy_in = 1'b1;
            @(negedge clk_in);
            e_ready = (c < 4);
            if (c == 0) e_inst = mem_word(32'h0000_1008);
            n_vec++;
            if ({fetch_ready, fetch_inst, mc_query_en, mc_query_addr} !== {e_ready, e_inst, e_qen, e_qaddr}) begin
                n_bad++;
                $display("FAIL pause_hold_ready cycle=%0d: rdy/inst/qen/qaddr got %b/%h/%b/%h want %b/%h/%b/%h",
                         c, fetch_ready, fetch_inst, mc_query_en, mc_query_addr,
                         e_ready, e_inst, e_qen, e_qaddr);
            end
        end
        do_fetch(32'h0000_2234, -1, 1, -1, "pause_mid_fill");
        do_fetch(32'h0000_2238, -1, -1, -1, "hit_after_pause");
    endtask

    task automatic test_reset_mid_fill();
        do_fetch(32'h0000_3304, -1, -1, 2, "reset_mid_fill");
        do_fetch(32'h0000_3304, -1, -1, -1, "refetch_after_reset");
        do_fetch(32'h0000_1000, -1, -1, -1, "all_invalid_after_reset");
    endtask

    task automatic test_random();
        logic [31:0] pc;
        int          r;
        int          clear_at;
        int          pause_at;
        int          rst_at;
        for (int i = 0; i < 60; i++) begin
            pc = 32'h0001_0000 | (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 7)) << 4)
                 | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            r        = int'($urandom_range(0, 11));
            clear_at = (r < 4) ? r : ((r == 4) ? 5 : -1);
            r        = int'($urandom_range(0, 7));
            pause_at = (r < 4) ? r : -1;
            rst_at   = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 3)) : -1;
            do_fetch(pc, clear_at, pause_at, rst_at, "random");
        end
    endtask

    initial begin
        seed = $urandom;
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_clear_fill();
        test_idle_clear();
        test_pause();
        test_reset_mid_fill();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
